// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared access-mode encodings, fault codes and LSU FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam logic [2:0] c_MODE_B  = 3'b000;
    localparam logic [2:0] c_MODE_H  = 3'b001;
    localparam logic [2:0] c_MODE_W  = 3'b010;
    localparam logic [2:0] c_MODE_BU = 3'b100;
    localparam logic [2:0] c_MODE_HU = 3'b101;

    localparam logic [1:0] c_FAULT_OK       = 2'b00;
    localparam logic [1:0] c_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] c_FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] c_FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } lsu_state_t;

    // Request-time fault classification; an illegal mode outranks misalignment.
    function automatic logic [1:0] f_access_fault(
        input logic       is_store,
        input logic [2:0] mode,
        input logic [1:0] addr_lo
    );
        logic legal;
        logic misaligned;
        case (mode)
            c_MODE_B, c_MODE_H, c_MODE_W: legal = 1'b1;
            c_MODE_BU, c_MODE_HU:         legal = ~is_store;
            default:                      legal = 1'b0;
        endcase
        case (mode)
            c_MODE_H, c_MODE_HU: misaligned = addr_lo[0];
            c_MODE_W:            misaligned = |addr_lo;
            default:             misaligned = 1'b0;
        endcase
        if (!legal) begin
            return c_FAULT_ILLEGAL;
        end
        if (misaligned) begin
            return c_FAULT_MISALIGN;
        end
        return c_FAULT_OK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering: store byte enables and lane replication,
//               load lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_mode,
    input  logic [1:0]       i_addr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [3:0]       o_be,
    output logic [WIDTH-1:0] o_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_mode)
            c_MODE_B, c_MODE_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {(WIDTH/8){i_wdata[7:0]}};
                o_rdata = (i_mode == c_MODE_B) ? {{(WIDTH-8){w_byte[7]}}, w_byte}
                                               : {{(WIDTH-8){1'b0}}, w_byte};
            end
            c_MODE_H, c_MODE_HU: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {(WIDTH/16){i_wdata[15:0]}};
                o_rdata = (i_mode == c_MODE_H) ? {{(WIDTH-16){w_half[15]}}, w_half}
                                               : {{(WIDTH-16){1'b0}}, w_half};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit with request/ack memory
//               handshake, alignment checks and wait-cycle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int n       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         MemRw,
    input  logic [2:0]   LoadStoreMode,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] rdata,
    output logic [1:0]   fault,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [3:0]   mem_be,
    output logic [n-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata
);

    localparam int                 c_CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    lsu_state_t         r_state;
    lsu_state_t         w_next;
    logic [n-1:0]       r_addr;
    logic [n-1:0]       r_wdata;
    logic               r_we;
    logic [2:0]         r_mode;
    logic [c_CNT_W-1:0] r_cnt;
    logic [n-1:0]       r_rdata;
    logic [1:0]         r_fault;

    logic [1:0]         w_req_fault;
    logic               w_in_req;
    logic [3:0]         w_be;
    logic [n-1:0]       w_store;
    logic [n-1:0]       w_load;

    assign w_req_fault = f_access_fault(MemRw, LoadStoreMode, addr[1:0]);
    assign w_in_req    = (r_state == ST_REQ);

    lsu_align #(
        .WIDTH (n)
    ) u_align (
        .i_mode    (r_mode),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_store),
        .o_rdata   (w_load)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_req_fault == c_FAULT_OK) ? ST_REQ : ST_FAULT;
                end
            end
            ST_REQ: begin
                // An ack on the final wait cycle still completes normally.
                if (mem_ack) begin
                    w_next = ST_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = ST_FAULT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_mode  <= c_MODE_B;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_fault <= c_FAULT_OK;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fault <= w_req_fault;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        if (w_req_fault == c_FAULT_OK) begin
                            r_addr  <= addr;
                            r_wdata <= wdata;
                            r_we    <= MemRw;
                            r_mode  <= LoadStoreMode;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_rdata <= r_we ? '0 : w_load;
                        r_fault <= c_FAULT_OK;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_CNT_LAST) begin
                            r_fault <= c_FAULT_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs are qualified by REQ so they read zero when idle.
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE) || (r_state == ST_FAULT);
    assign rdata     = r_rdata;
    assign fault     = r_fault;
    assign mem_req   = w_in_req;
    assign mem_we    = w_in_req & r_we;
    assign mem_addr  = w_in_req ? {r_addr[n-1:2], 2'b00} : '0;
    assign mem_be    = w_in_req ? w_be : 4'b0000;
    assign mem_wdata = w_in_req ? w_store : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench: directed vector table, reset/busy
//               sequences and randomized accesses against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int c_TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        MemRw;
    logic [2:0]  LoadStoreMode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .n       (32),
        .TIMEOUT (c_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .MemRw         (MemRw),
        .LoadStoreMode (LoadStoreMode),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .rdata         (rdata),
        .fault         (fault),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        string       nm;
        logic        st;
        logic [2:0]  mode;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          wt;
        logic [1:0]  f;
        logic [31:0] rd_exp;
        logic [3:0]  be;
        logic [31:0] wd_exp;
        int          lat;
        int          nreq;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour from the access rules: size, offset, lane math.
    function automatic void model(
        input  logic st, input logic [2:0] mode, input logic [31:0] a, wd, rd, input int wt,
        output logic [1:0] f, output logic [31:0] rdat, output logic [3:0] be,
        output logic [31:0] swd, output int lat, output int nreq);
        int          sz;
        int          off;
        bit          legal;
        logic [31:0] mask;
        logic [31:0] v;
        legal = st ? (mode <= 3'd2) : (mode <= 3'd2 || mode == 3'd4 || mode == 3'd5);
        sz    = 1 << mode[1:0];
        off   = int'(a[1:0]);
        f     = !legal ? 2'b10 : ((off % sz) != 0 ? 2'b01 : 2'b00);
        be    = 4'(((1 << sz) - 1) << off);
        mask  = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
        v     = (rd >> (8 * off)) & mask;
        if (!mode[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        swd   = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        rdat  = 32'h0;
        if (f != 2'b00) begin
            lat  = 1;
            nreq = 0;
        end else if (wt < 0 || wt >= c_TO) begin
            f    = 2'b11;
            lat  = c_TO + 1;
            nreq = c_TO;
        end else begin
            lat  = wt + 2;
            nreq = wt + 1;
            rdat = st ? 32'h0 : v;
        end
    endfunction

    // Issues one access, acks after wt REQ wait cycles (wt<0: never), and
    // returns one cycle after done so the next start is back-to-back.
    task automatic access(
        input  logic st, input logic [2:0] mode, input logic [31:0] a, wd, rd, input int wt,
        output int lat, output int nreq, output logic [3:0] o_be, output logic [31:0] o_wd,
        output logic o_we, output logic [31:0] o_ma, output bit stable, output bit busy_ok,
        output logic [31:0] o_rd, output logic [1:0] o_f, output bit got_done);
        int cyc;
        start = 1'b1; MemRw = st; LoadStoreMode = mode; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = $urandom;
        nreq = 0; stable = 1'b1; busy_ok = 1'b1; got_done = 1'b0; lat = -1;
        o_be = '0; o_wd = '0; o_we = 1'b0; o_ma = '0; o_rd = '0; o_f = '0;
        tick;
        cyc = 1;
        start = 1'b0; addr = $urandom; wdata = $urandom; MemRw = ~st; LoadStoreMode = 3'($urandom);
        while (!got_done && cyc < c_TO + 20) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                got_done = 1'b1;
                lat      = cyc;
                o_rd     = rdata;
                o_f      = fault;
                mem_ack  = 1'($urandom_range(0, 1));
            end else begin
                if (mem_req) begin
                    if (nreq == 0) begin
                        o_be = mem_be; o_wd = mem_wdata; o_we = mem_we; o_ma = mem_addr;
                    end else if ({mem_be, mem_wdata, mem_we, mem_addr} != {o_be, o_wd, o_we, o_ma}) begin
                        stable = 1'b0;
                    end
                    if (nreq == wt) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                    end
                    nreq++;
                end
                tick;
                cyc++;
            end
        end
        if (got_done) tick;
        mem_ack = 1'b0;
    endtask

    task automatic run_check(
        input string nm, input logic st, input logic [2:0] mode, input logic [31:0] a, wd, rd,
        input int wt, input logic [1:0] ef, input logic [31:0] erd, input logic [3:0] ebe,
        input logic [31:0] ewd, input int elat, input int enreq);
        int          lat, nreq;
        logic [3:0]  o_be;
        logic [31:0] o_wd, o_ma, o_rd;
        logic        o_we;
        logic [1:0]  o_f;
        bit          stable, busy_ok, got_done;
        access(st, mode, a, wd, rd, wt, lat, nreq, o_be, o_wd, o_we, o_ma, stable, busy_ok,
               o_rd, o_f, got_done);
        chk({nm, ".done_seen"}, 32'(got_done), 32'd1);
        chk({nm, ".fault"}, 32'(o_f), 32'(ef));
        chk({nm, ".latency"}, 32'(lat), 32'(elat));
        chk({nm, ".req_cycles"}, 32'(nreq), 32'(enreq));
        chk({nm, ".busy_while_active"}, 32'(busy_ok), 32'd1);
        if (ef == 2'b00) chk({nm, ".rdata"}, o_rd, erd);
        if (enreq > 0) begin
            chk({nm, ".mem_be"}, 32'(o_be), 32'(ebe));
            chk({nm, ".mem_we"}, 32'(o_we), 32'(st));
            chk({nm, ".mem_addr"}, o_ma, a & 32'hFFFF_FFFC);
            chk({nm, ".stable"}, 32'(stable), 32'd1);
            if (st) chk({nm, ".mem_wdata"}, o_wd, ewd);
        end
        chk({nm, ".idle_after_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        vec_t vecs[16];
        logic [1:0]  mf;
        logic [31:0] mrd, mwd, ra, rwd, rrd;
        logic [3:0]  mbe;
        logic [2:0]  rmode;
        logic        rst_ok, rst_st;
        int          mlat, mnreq, rwt;

        vecs[0]  = '{"lw_100",     1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  2'b00, 32'hDEADBEEF, 4'hF, 32'h0,        2,  1};
        vecs[1]  = '{"lb_103",     1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0,  2'b00, 32'hFFFFFF80, 4'h8, 32'h0,        2,  1};
        vecs[2]  = '{"lbu_103",    1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 0,  2'b00, 32'h00000080, 4'h8, 32'h0,        2,  1};
        vecs[3]  = '{"sh_102",     1'b1, 3'b001, 32'h102, 32'h00001234, 32'h55555555, 3,  2'b00, 32'h0,        4'hC, 32'h12341234, 5,  4};
        vecs[4]  = '{"lw_101",     1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0,  2'b01, 32'h0,        4'h0, 32'h0,        1,  0};
        vecs[5]  = '{"st_mode4",   1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0,  2'b10, 32'h0,        4'h0, 32'h0,        1,  0};
        vecs[6]  = '{"lh_102",     1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 0,  2'b00, 32'hFFFF8001, 4'hC, 32'h0,        2,  1};
        vecs[7]  = '{"lhu_100",    1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 0,  2'b00, 32'h0000F00D, 4'h3, 32'h0,        2,  1};
        vecs[8]  = '{"sb_101",     1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        0,  2'b00, 32'h0,        4'h2, 32'hABABABAB, 2,  1};
        vecs[9]  = '{"sw_104",     1'b1, 3'b010, 32'h104, 32'hCAFEBABE, 32'h0,        1,  2'b00, 32'h0,        4'hF, 32'hCAFEBABE, 3,  2};
        vecs[10] = '{"ld_m3_101",  1'b0, 3'b011, 32'h101, 32'h0,        32'h0,        0,  2'b10, 32'h0,        4'h0, 32'h0,        1,  0};
        vecs[11] = '{"lh_101",     1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0,  2'b01, 32'h0,        4'h0, 32'h0,        1,  0};
        vecs[12] = '{"sw_102",     1'b1, 3'b010, 32'h102, 32'h0,        32'h0,        0,  2'b01, 32'h0,        4'h0, 32'h0,        1,  0};
        vecs[13] = '{"st_m5_103",  1'b1, 3'b101, 32'h103, 32'h0,        32'h0,        0,  2'b10, 32'h0,        4'h0, 32'h0,        1,  0};
        vecs[14] = '{"lw_timeout", 1'b0, 3'b010, 32'h200, 32'h0,        32'h0,        -1, 2'b11, 32'h0,        4'hF, 32'h0,        c_TO + 1, c_TO};
        vecs[15] = '{"lw_ack_last",1'b0, 3'b010, 32'h200, 32'h0,        32'h12345678, c_TO - 1, 2'b00, 32'h12345678, 4'hF, 32'h0, c_TO + 1, c_TO};

        rst = 1'b1; start = 1'b0; MemRw = 1'b0; LoadStoreMode = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick;
        tick;
        chk("reset.busy_done", {30'd0, busy, done}, 32'd0);
        chk("reset.fault", 32'(fault), 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.mem_req_we", {30'd0, mem_req, mem_we}, 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.mem_be", 32'(mem_be), 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 16; i++) begin
            run_check(vecs[i].nm, vecs[i].st, vecs[i].mode, vecs[i].a, vecs[i].wd, vecs[i].rd,
                      vecs[i].wt, vecs[i].f, vecs[i].rd_exp, vecs[i].be, vecs[i].wd_exp,
                      vecs[i].lat, vecs[i].nreq);
        end

        // Reset in the middle of a pending load, with an ack racing it.
        start = 1'b1; MemRw = 1'b0; LoadStoreMode = 3'b010; addr = 32'h300;
        tick;
        start = 1'b0;
        chk("rst_req.req_up", 32'(mem_req), 32'd1);
        tick;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick;
        rst = 1'b0; mem_ack = 1'b0;
        chk("rst_req.req_dropped", {30'd0, mem_req, busy}, 32'd0);
        chk("rst_req.no_done", 32'(done), 32'd0);
        chk("rst_req.mem_addr", mem_addr, 32'd0);
        chk("rst_req.rdata", rdata, 32'd0);
        rst_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            tick;
            if (done || busy || mem_req) rst_ok = 1'b0;
        end
        mem_ack = 1'b0;
        chk("rst_req.quiet_after", 32'(rst_ok), 32'd1);

        // start held high while busy must not disturb the access in flight.
        start = 1'b1; MemRw = 1'b1; LoadStoreMode = 3'b010; addr = 32'h40; wdata = 32'h11111111;
        tick;
        MemRw = 1'b0; LoadStoreMode = 3'b000; addr = 32'h83; wdata = 32'h22222222;
        tick;
        chk("busy_start.mem_addr", mem_addr, 32'h40);
        chk("busy_start.mem_wdata", mem_wdata, 32'h11111111);
        chk("busy_start.mem_we_be", {27'd0, mem_we, mem_be}, {27'd0, 1'b1, 4'hF});
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        rst_st = done;
        chk("busy_start.done", {29'd0, rst_st, fault}, {29'd0, 1'b1, 2'b00});
        chk("busy_start.rdata", rdata, 32'd0);
        start = 1'b0;
        tick;
        chk("busy_start.idle", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            rmode = 3'($urandom_range(0, 7));
            rst_st = 1'($urandom_range(0, 1));
            ra    = $urandom;
            rwd   = $urandom;
            rrd   = $urandom;
            rwt   = $urandom_range(0, 4);
            model(rst_st, rmode, ra, rwd, rrd, rwt, mf, mrd, mbe, mwd, mlat, mnreq);
            run_check($sformatf("rnd%0d", i), rst_st, rmode, ra, rwd, rrd, rwt,
                      mf, mrd, mbe, mwd, mlat, mnreq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The parameter n SHALL default to 32 and set the data and address width.
REQ-002 The parameter TIMEOUT SHALL default to 255 and set the maximum cycles spent waiting for mem_ack.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  core requests one memory access this cycle
- MemRw  in  1  1 = store, 0 = load, from the decoder
- LoadStoreMode  in  3  funct3 from the decoder: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  n  byte address (ALU result)
- wdata  in  n  store data (rs2)
- busy  out  1  access in flight; core stalls PC
- done  out  1  one-cycle completion pulse
- rdata  out  n  aligned, extended load result; valid when done=1
- fault  out  2  valid when done=1: 00 ok, 01 misaligned, 10 illegal mode, 11 timeout
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  n  word address: addr with bits [1:0] forced to 00
- mem_be  out  4  byte enables
- mem_wdata  out  n  lane-replicated store data
- mem_ack  in  1  memory accepted the write or returned read data
- mem_rdata  in  n  read word

Function
REQ-005 The FSM SHALL have states IDLE, REQ, DONE and FAULT.
REQ-006 In IDLE, start=1 with a legal, aligned access SHALL capture addr, wdata, MemRw and LoadStoreMode, then go to REQ.
REQ-007 In IDLE, start=1 with an illegal mode or misaligned address SHALL go to FAULT without asserting mem_req.
REQ-008 Legal modes SHALL be: loads 000, 001, 010, 100, 101; stores 000, 001, 010; every other combination is illegal (fault=10).
REQ-009 An access SHALL be misaligned when it is a halfword with addr[0]=1 or a word with addr[1:0]≠00 (fault=01); when the mode is also illegal, illegal SHALL take precedence.
REQ-010 In REQ, mem_req SHALL be 1 and mem_addr, mem_we, mem_be and mem_wdata SHALL stay stable until mem_ack=1; the transition to DONE SHALL occur on the mem_ack edge.
REQ-011 Byte enables SHALL be: B/BU 0001<<addr[1:0]; H/HU 0011<<(2*addr[1]); W 1111.
REQ-012 Store data SHALL be: B = byte replicated ×4; H = halfword replicated ×2; W = wdata unchanged.
REQ-013 Load data SHALL be taken from the selected lane of mem_rdata: B/H sign-extend, BU/HU zero-extend, W unchanged; it SHALL be registered into rdata on the mem_ack edge.
REQ-014 For stores, rdata SHALL be 0 at done.
REQ-015 In DONE and FAULT, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; fault SHALL be 00 in DONE.
REQ-016 A wait-cycle counter SHALL clear on entry to REQ and increment each cycle in REQ without mem_ack.
- When it reaches TIMEOUT, the FSM SHALL drop mem_req and go to FAULT with fault=11.
- A mem_ack in the same cycle as the timeout SHALL win, giving a normal DONE.
REQ-017 busy SHALL be 1 in REQ, DONE and FAULT, and 0 in IDLE.
REQ-018 start while busy=1 SHALL be ignored; back-to-back accesses SHALL be possible with start asserted in the cycle after done.
REQ-019 Latency with zero-wait memory (mem_ack in the first REQ cycle): start at cycle 0, mem_req at cycle 1, done at cycle 2. Each memory wait cycle SHALL add one cycle.
REQ-020 mem_ack outside REQ SHALL be ignored.

Reset
REQ-021 While rst=1, the FSM SHALL go to IDLE and the following SHALL be 0: busy, done, fault, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata, and the wait counter.
REQ-022 Reset during REQ SHALL deassert mem_req on that edge and SHALL produce no done pulse.

Structure
REQ-023 The LoadStoreMode encodings, fault codes and FSM state encodings SHALL reside in a shared package used by control and this block.
REQ-024 Lane alignment and extension SHALL be one combinational sub-module, lsu_align (store lane/byte-enable generation and load extract/extend).

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- LW at addr 0x100, mem_rdata 0xDEADBEEF, ack in first REQ cycle -> done at cycle 2, rdata=0xDEADBEEF, fault=00, mem_be=1111.
- LB at 0x103, mem_rdata 0x80FF_FFFF -> rdata=0xFFFFFF80; LBU same -> 0x00000080; mem_addr=0x100.
- SH at 0x102, wdata 0x0000_1234, ack after 3 wait cycles -> mem_be=1100, mem_wdata=0x12341234, mem_we=1, signals stable for 4 cycles, done at cycle 5.
- LW at 0x101 -> FAULT: no mem_req, done with fault=01; store with mode 100 -> fault=10.
- mem_ack withheld -> mem_req drops and done with fault=11 after TIMEOUT cycles; ack on the timeout cycle -> fault=00.
- rst asserted during REQ -> mem_req=0 next cycle, no done; start while busy ignored.
